// File: rtl/dct_it_math_if.sv
// Valid-qualified coefficient/sample bus for the 8-point inverse binDCT.
// The decoder drives in_*, the transform drives out_*.
interface dct_it_math_if #(
    parameter int W_I = 16,
    parameter int W_O = 8
);
    logic                  in_valid;
    logic [7:0][W_I-1:0]   in_data;
    logic                  out_valid;
    logic [7:0][W_O-1:0]   out_data;
    logic                  out_sat;

    modport master (
        output in_valid, in_data,
        input  out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_data,
        output out_valid, out_data, out_sat
    );
endinterface

// File: rtl/dct_it_math.sv
// 8-point inverse binDCT, exact lifting inverse of dct_ft_math.
// Fully pipelined, one vector per cycle, 8-cycle latency, saturated output.
module dct_it_math #(
    parameter int W_I = 16,
    parameter int W_O = 8
) (
    input  logic        clk,
    input  logic        rst,
    dct_it_math_if.slave bus
);

    localparam int W       = W_I + 6;
    localparam int O_MAX_I = (1 << (W_O - 1)) - 1;

    typedef logic signed [W-1:0] lane_t;
    typedef lane_t vec_t [8];

    localparam lane_t O_MAX = lane_t'(O_MAX_I);
    localparam lane_t O_MIN = lane_t'(-O_MAX_I - 1);

    // Round to the nearest multiple of 8, halves away from zero.
    function automatic lane_t rnd(input lane_t u);
        lane_t q;
        logic  inc;
        q   = u >>> 3;
        inc = u[2] & (~u[W-1] | u[1] | u[0]);
        return (q + lane_t'(inc)) <<< 3;
    endfunction

    function automatic lane_t p3(input lane_t v);
        return rnd((v >>> 3) + (v >>> 2));
    endfunction

    function automatic lane_t p5(input lane_t v);
        return rnd((v >>> 3) + (v >>> 1));
    endfunction

    function automatic lane_t p7(input lane_t v);
        return rnd((v >>> 3) + (v >>> 2) + (v >>> 1));
    endfunction

    function automatic lane_t hf(input lane_t v);
        return rnd(v >>> 1);
    endfunction

    function automatic lane_t ef(input lane_t v);
        return rnd(v >>> 3);
    endfunction

    // Butterfly halvings keep the carry bit so the sum never wraps before the shift.
    function automatic lane_t hadd(input lane_t a, input lane_t b);
        logic [W:0] s;
        s = {a[W-1], a} + {b[W-1], b};
        return s[W:1];
    endfunction

    function automatic lane_t hsub(input lane_t a, input lane_t b);
        logic [W:0] s;
        s = {a[W-1], a} - {b[W-1], b};
        return s[W:1];
    endfunction

    logic [8:0]            v_q;
    vec_t                  c_q, a_q, b_q, s3_q, s4_q, s5_q, x_q;
    vec_t                  c_n, a_n, b_n, s3_n, s4_n, s5_n, x_n;
    logic [7:0][W_O-1:0]   k_q, k_n, o_q;
    logic                  k_sat_q, k_sat_n, o_sat_q;
    lane_t                 fl;

    always_comb begin
        // NOTE: every always_comb output gets a full default first so no path can infer a latch.
        c_n     = c_q;
        a_n     = c_q;
        b_n     = a_q;
        s3_n    = b_q;
        s4_n    = s3_q;
        s5_n    = s4_q;
        x_n     = s5_q;
        k_n     = '0;
        k_sat_n = 1'b0;
        fl      = '0;

        for (int i = 0; i < 8; i++) begin
            c_n[i] = lane_t'({{6{bus.in_data[i][W_I-1]}}, bus.in_data[i]}) <<< 3;
        end

        a_n[1] = hf(c_q[0]) - c_q[1];
        a_n[3] = c_q[3] - p3(c_q[2]);
        a_n[4] = c_q[4] + ef(c_q[7]);
        a_n[6] = c_q[6] + hf(c_q[5]);

        b_n[0] = a_q[0] - a_q[1];
        b_n[2] = a_q[2] + p3(a_q[3]);
        b_n[5] = a_q[5] - p7(a_q[6]);

        s3_n[0] = hadd(b_q[0], b_q[3]);
        s3_n[3] = hsub(b_q[0], b_q[3]);
        s3_n[1] = hadd(b_q[1], b_q[2]);
        s3_n[2] = hsub(b_q[1], b_q[2]);
        s3_n[4] = hadd(b_q[4], b_q[5]);
        s3_n[5] = hsub(b_q[4], b_q[5]);
        s3_n[7] = hadd(b_q[7], b_q[6]);
        s3_n[6] = hsub(b_q[7], b_q[6]);

        s4_n[5] = p5(s3_q[6]) - s3_q[5];
        s5_n[6] = s4_q[6] - p3(s4_q[5]);

        for (int i = 0; i < 4; i++) begin
            x_n[i]     = hadd(s5_q[i], s5_q[7-i]);
            x_n[7-i]   = hsub(s5_q[i], s5_q[7-i]);
        end

        for (int i = 0; i < 8; i++) begin
            fl = x_q[i] >>> 3;
            if (fl > O_MAX) begin
                k_n[i]  = O_MAX[W_O-1:0];
                k_sat_n = 1'b1;
            end else if (fl < O_MIN) begin
                k_n[i]  = O_MIN[W_O-1:0];
                k_sat_n = 1'b1;
            end else begin
                k_n[i]  = fl[W_O-1:0];
            end
        end
    end

    // Clip result is registered once more so the compare chain never reaches the port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: data registers are reset too, so the bus reads all-zero before the first result.
            v_q     <= '0;
            c_q     <= '{default: '0};
            a_q     <= '{default: '0};
            b_q     <= '{default: '0};
            s3_q    <= '{default: '0};
            s4_q    <= '{default: '0};
            s5_q    <= '{default: '0};
            x_q     <= '{default: '0};
            k_q     <= '0;
            k_sat_q <= 1'b0;
            o_q     <= '0;
            o_sat_q <= 1'b0;
        end else begin
            v_q <= {v_q[7:0], bus.in_valid};
            if (bus.in_valid) c_q  <= c_n;
            if (v_q[0])       a_q  <= a_n;
            if (v_q[1])       b_q  <= b_n;
            if (v_q[2])       s3_q <= s3_n;
            if (v_q[3])       s4_q <= s4_n;
            if (v_q[4])       s5_q <= s5_n;
            if (v_q[5])       x_q  <= x_n;
            if (v_q[6]) begin
                k_q     <= k_n;
                k_sat_q <= k_sat_n;
            end
            if (v_q[7]) begin
                o_q     <= k_q;
                o_sat_q <= k_sat_q;
            end
        end
    end

    assign bus.out_valid = v_q[8];
    assign bus.out_data  = o_q;
    assign bus.out_sat   = o_sat_q;

endmodule

// File: tb/tb_dct_it_math.sv
// Directed + random bench for dct_it_math against an integer reference of the inverse binDCT.
// A cycle-stamped queue predicts out_valid/out_data/out_sat on every cycle.
module tb_dct_it_math;

    localparam int W_I = 16;
    localparam int W_O = 8;
    localparam int W   = W_I + 6;

    typedef struct {
        int              due;
        logic [7:0][7:0] d;
        logic            s;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   edge_n = 0;
    int   tests  = 0;
    int   fails  = 0;

    exp_t            exp_q[$];
    logic [7:0][7:0] last_d = '0;
    logic            last_s = 1'b0;
    logic [65:0]     mon_exp;

    dct_it_math_if #(.W_I(W_I), .W_O(W_O)) bus ();

    dct_it_math #(.W_I(W_I), .W_O(W_O)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n++;

    task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s edge %0d: observed %h expected %h", tag, edge_n, obs, exp);
        end
    endtask

    // ---------------- reference model (plain integer arithmetic) ----------------
    function automatic longint wr(input longint v);
        longint m;
        m = v & ((64'sd1 <<< W) - 1);
        if (m >= (64'sd1 <<< (W - 1))) m -= (64'sd1 <<< W);
        return m;
    endfunction

    function automatic longint rr(input longint u);
        longint q, f;
        q = u >>> 3;
        f = u - q * 8;
        if (f > 4 || (f == 4 && u >= 0)) q++;
        return wr(q * 8);
    endfunction

    function automatic longint mp3(input longint v);
        return rr(wr((v >>> 3) + (v >>> 2)));
    endfunction

    function automatic longint mp5(input longint v);
        return rr(wr((v >>> 3) + (v >>> 1)));
    endfunction

    function automatic longint mp7(input longint v);
        return rr(wr((v >>> 3) + (v >>> 2) + (v >>> 1)));
    endfunction

    function automatic logic [64:0] model(input logic [7:0][15:0] y);
        longint          t[8];
        longint          s[8];
        longint          x[8];
        longint          o;
        logic [7:0][7:0] d;
        logic            sat;
        for (int i = 0; i < 8; i++) t[i] = longint'($signed(y[i])) * 8;
        t[1] = wr(rr(t[1 - 1] >>> 1) - t[1]);
        t[3] = wr(t[3] - mp3(t[2]));
        t[4] = wr(t[4] + rr(t[7] >>> 3));
        t[6] = wr(t[6] + rr(t[5] >>> 1));
        t[0] = wr(t[0] - t[1]);
        t[2] = wr(t[2] + mp3(t[3]));
        t[5] = wr(t[5] - mp7(t[6]));
        s[0] = (t[0] + t[3]) >>> 1;  s[3] = (t[0] - t[3]) >>> 1;
        s[1] = (t[1] + t[2]) >>> 1;  s[2] = (t[1] - t[2]) >>> 1;
        s[4] = (t[4] + t[5]) >>> 1;  s[5] = (t[4] - t[5]) >>> 1;
        s[7] = (t[7] + t[6]) >>> 1;  s[6] = (t[7] - t[6]) >>> 1;
        s[5] = wr(mp5(s[6]) - s[5]);
        s[6] = wr(s[6] - mp3(s[5]));
        for (int i = 0; i < 4; i++) begin
            x[i]     = (s[i] + s[7-i]) >>> 1;
            x[7-i]   = (s[i] - s[7-i]) >>> 1;
        end
        sat = 1'b0;
        for (int i = 0; i < 8; i++) begin
            o = x[i] >>> 3;
            if (o > 127) begin
                o = 127;  sat = 1'b1;
            end else if (o < -128) begin
                o = -128; sat = 1'b1;
            end
            d[i] = o[7:0];
        end
        return {sat, d};
    endfunction

    // ---------------- output monitor ----------------
    always @(negedge clk) begin
        if (exp_q.size() != 0 && exp_q[0].due == edge_n) begin
            last_d  = exp_q[0].d;
            last_s  = exp_q[0].s;
            mon_exp = {1'b1, last_s, last_d};
            void'(exp_q.pop_front());
        end else begin
            mon_exp = {1'b0, last_s, last_d};
        end
        check(rst ? "reset_out" : "out", {bus.out_valid, bus.out_sat, bus.out_data}, mon_exp);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0][15:0] y, input logic v);
        logic [64:0] m;
        exp_t        e;
        bus.in_valid = v;
        bus.in_data  = y;
        if (v && !rst) begin
            m     = model(y);
            e.due = edge_n + 9;
            e.d   = m[63:0];
            e.s   = m[64];
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            drive('0, 1'b0);
        end
    endtask

    function automatic logic [7:0][15:0] rand_vec(input bit wide);
        logic [7:0][15:0] y;
        for (int i = 0; i < 8; i++) begin
            if (wide) y[i] = 16'($urandom);
            else      y[i] = 16'(int'($urandom_range(0, 600)) - 300);
        end
        return y;
    endfunction

    function automatic logic [7:0][15:0] dc_vec(input int v);
        logic [7:0][15:0] y;
        y    = '0;
        y[0] = 16'(v);
        return y;
    endfunction

    function automatic logic [7:0][15:0] fill_vec(input logic [15:0] v);
        logic [7:0][15:0] y;
        for (int i = 0; i < 8; i++) y[i] = v;
        return y;
    endfunction

    initial begin
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        #1 rst = 1'b1;

        // reset held with live valid inputs: nothing may emerge
        for (int i = 0; i < 6; i++) begin
            tick();
            drive(rand_vec(1'b1), 1'b1);
        end

        // release with DC vector presented in the same cycle
        tick();
        rst = 1'b0;
        drive(dc_vec(64), 1'b1);
        idle(11);

        // saturation both ways
        tick(); drive(dc_vec(2048), 1'b1);
        tick(); drive(dc_vec(-2048), 1'b1);
        idle(10);

        // streaming with a 2-cycle bubble
        for (int k = 1; k <= 10; k++) begin
            tick();
            drive(dc_vec(8 * k), 1'b1);
        end
        idle(2);
        tick(); drive(dc_vec(88), 1'b1);
        idle(10);

        // extreme coefficient corners and alternating patterns
        tick(); drive(fill_vec(16'h7fff), 1'b1);
        tick(); drive(fill_vec(16'h8000), 1'b1);
        tick(); drive({16'd127, 16'hff80, 16'd127, 16'hff80, 16'd127, 16'hff80, 16'd127, 16'hff80}, 1'b1);
        tick(); drive(fill_vec(16'hff80), 1'b1);
        idle(10);

        // random traffic with random bubbles
        for (int i = 0; i < 400; i++) begin
            tick();
            drive(rand_vec($urandom_range(0, 3) == 0), $urandom_range(0, 3) != 0);
        end
        idle(10);

        // reset pulse with three vectors in flight
        for (int i = 0; i < 3; i++) begin
            tick();
            drive(rand_vec(1'b0), 1'b1);
        end
        tick();
        rst = 1'b1;
        exp_q.delete();
        last_d = '0;
        last_s = 1'b0;
        drive(rand_vec(1'b0), 1'b1);
        tick();
        rst = 1'b0;
        drive(rand_vec(1'b0), 1'b1);
        idle(12);

        check("drained", 66'(exp_q.size()), 66'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dct_it_math.md
# dct_it_math

- 8-point inverse binDCT: the exact lifting inverse of the `dct_ft_math` forward transform.
- Accepts one vector of eight signed coefficients per cycle and returns eight signed, saturated samples.
- Fixed latency of 8 cycles; valid-qualified, fully pipelined.
- Sits in the decode path between dequantization and level-shift/pixel packing.

## Interface
- `W_I`, default 16: signed width of each input coefficient.
- `W_O`, default 8: signed width of each output sample.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `in_valid`  in  1  `in_data` holds a vector this cycle.
- `in_data`  in  [7:0][W_I-1:0]  coefficients y0..y7, in the same lane order the forward block produces.
- `out_valid`  out  1  `out_data` holds a result vector.
- `out_data`  out  [7:0][W_O-1:0]  reconstructed samples x0..x7.
- `out_sat`  out  1  with `out_valid`: at least one lane of this vector was clipped.

## Operation
**Number format**
- Internal width W = W_I+6 bits, signed: 3 fractional bits plus 3 guard bits.
- Each input is sign-extended and shifted left by 3 on capture.
- Add/subtract results wrap at W bits.
- A halving `h(a±b)` computes the sum at W+1 bits, then shifts right arithmetically by 1.

**Rounding `R(u)`**, applied to a W-bit value u:
- q = u>>>3.
- Increment q when u[2] & (~u[W-1] | u[1] | u[0]), i.e. round half away from zero.
- The result is q<<3.

**Scaled terms**, formed with arithmetic shifts before rounding:
- P3(v) = R((v>>>3)+(v>>>2))
- P5(v) = R((v>>>3)+(v>>>1))
- P7(v) = R((v>>>3)+(v>>>2)+(v>>>1))
- H(v) = R(v>>>1)
- E(v) = R(v>>>3)

**Pipeline stages.** Lanes not listed pass through unchanged.
- S0 (capture): t[i] = in_data[i]<<3.
- S1: t1 = H(t0) - t1; t3 = t3 - P3(t2); t4 = t4 + E(t7); t6 = t6 + H(t5).
- S2: t0 = t0 - t1; t2 = t2 + P3(t3); t5 = t5 - P7(t6).
- S3, lane-pair butterflies:
  - s0 = h(t0+t3), s3 = h(t0-t3)
  - s1 = h(t1+t2), s2 = h(t1-t2)
  - s4 = h(t4+t5), s5 = h(t4-t5)
  - s7 = h(t7+t6), s6 = h(t7-t6)
- S4: s5 = P5(s6) - s5.
- S5: s6 = s6 - P3(s5).
- S6, output butterflies: for i = 0..3, x_i = h(s_i + s_{7-i}) and x_{7-i} = h(s_i - s_{7-i}).
- S7 (output register):
  - Each lane is x>>>3 (floor), saturated to [-2^(W_O-1), 2^(W_O-1)-1].
  - `out_sat` is the OR of the per-lane clip flags.

**Valid and enables**
- A valid bit travels alongside every stage.
- A stage's data registers load only when its incoming valid is 1; otherwise they hold.
- `out_data` and `out_sat` hold the last valid result while `out_valid` = 0.
- There is no backpressure: the consumer must accept one vector per cycle.
- A coefficient vector produced by `dct_ft_math` from W_O-bit samples reconstructs bit-exactly, with no clipping.

## Timing
**Reset values**
- `out_valid` = 0, `out_data` = all 0, `out_sat` = 0.
- All stage registers and valid bits are 0.

**Latency and throughput**
- Latency: `in_valid` sampled high at edge N gives `out_valid` = 1 after edge N+8.
- Throughput: 1 vector/cycle.
- Bubbles in `in_valid` appear unchanged, and in order, at the output.

**Reset boundary cases**
- `rst` asserted mid-stream clears every valid bit immediately (asynchronously). In-flight vectors are dropped and never emitted.
- After `rst` deasserts, the first `out_valid` occurs exactly 8 cycles after the first new `in_valid`.
- `in_valid` high in the cycle `rst` deasserts is captured only if `rst` is low at that edge.

## Test plan
- **Reset:** hold `rst` while driving random inputs with `in_valid` = 1 -> `out_valid` = 0, `out_data` = 0, `out_sat` = 0 throughout; first output appears 8 cycles after release.
- **DC:** y0 = 64, others 0, one cycle -> 8 cycles later, all eight lanes = 8, `out_sat` = 0, `out_valid` high for exactly 1 cycle.
- **Saturation:** y0 = 2048 -> all lanes 127, `out_sat` = 1. y0 = -2048 -> all lanes -128, `out_sat` = 1.
- **Streaming:** 10 back-to-back vectors y0 = 8k (k = 1..10), then a 2-cycle bubble, then k = 11 -> lanes = k in order, with the bubble preserved at the output.
- **Round trip:** chain `dct_ft_math` -> this block; drive 10^4 random 8-bit vectors plus corners (all -128, all 127, alternating ±128/127) -> output equals input bit-exactly, `out_sat` = 0.
- **Reset mid-flight:** pulse `rst` for 1 cycle while 3 vectors are in flight -> those 3 are never emitted; the next vector arrives with correct 8-cycle latency.
